// File: rtl/ctrl_pkg.sv
// Shared encodings and per-state output decode for the multi-cycle control FSM.
// The exception state is only decoded when OVERFLOW_EXC_EN is defined.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_EXC       = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011
  } alu_op_t;

  typedef enum logic [1:0] {
    B_REG     = 2'b00,
    B_FOUR    = 2'b01,
    B_IMM     = 2'b10,
    B_IMM_SL2 = 2'b11
  } mux_b_t;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10,
    PC_EXC    = 2'b11
  } pc_src_t;

  typedef struct packed {
    logic    mux_a_sel;
    mux_b_t  mux_b_sel;
    alu_op_t alu_op;
    pc_src_t pc_src;
    logic    pc_write;
    logic    pc_write_cond;
    logic    iord;
    logic    mem_read;
    logic    mem_write;
    logic    ir_write;
    logic    reg_write;
    logic    reg_dst;
    logic    mem_to_reg;
    logic    epc_write;
  } ctrl_out_t;

  // Moore outputs of a state; r_op is the ALU op latched from funct at decode.
  function automatic ctrl_out_t state_outputs(input state_t s, input alu_op_t r_op);
    ctrl_out_t o;
    o = '0;
    case (s)
      S_FETCH: begin
        o.mem_read  = 1'b1;
        o.mux_b_sel = B_FOUR;
      end
      S_DECODE:    o.mux_b_sel = B_IMM_SL2;
      S_MEM_ADDR, S_ADDI_EXEC: begin
        o.mux_a_sel = 1'b1;
        o.mux_b_sel = B_IMM;
      end
      S_MEM_READ: begin
        o.iord     = 1'b1;
        o.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        o.reg_write  = 1'b1;
        o.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        o.iord      = 1'b1;
        o.mem_write = 1'b1;
      end
      S_R_EXEC: begin
        o.mux_a_sel = 1'b1;
        o.alu_op    = r_op;
      end
      S_R_WB: begin
        o.mux_a_sel = 1'b1;
        o.alu_op    = r_op;
        o.reg_write = 1'b1;
        o.reg_dst   = 1'b1;
      end
      S_ADDI_WB:   o.reg_write = 1'b1;
      S_BRANCH: begin
        o.mux_a_sel     = 1'b1;
        o.alu_op        = ALU_SUB;
        o.pc_write_cond = 1'b1;
        o.pc_src        = PC_ALUOUT;
      end
      S_JUMP: begin
        o.pc_write = 1'b1;
        o.pc_src   = PC_JUMP;
      end
`ifdef OVERFLOW_EXC_EN
      S_EXC: begin
        o.epc_write = 1'b1;
        o.pc_write  = 1'b1;
        o.pc_src    = PC_EXC;
        o.mux_b_sel = B_FOUR;
        o.alu_op    = ALU_SUB;
      end
`endif
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/alu_dec.sv
// R-type funct field to ALU operation decoder with a supported-funct flag.
module alu_dec
  import ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output alu_op_t    alu_op_o,
  output logic       valid_o
);

  always_comb begin
    alu_op_o = ALU_ADD;
    valid_o  = 1'b1;
    case (funct_i)
      FN_ADD:  alu_op_o = ALU_ADD;
      FN_SUB:  alu_op_o = ALU_SUB;
      FN_AND:  alu_op_o = ALU_AND;
      FN_OR:   alu_op_o = ALU_OR;
      default: valid_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle datapath control FSM with registered outputs.
// OVERFLOW_EXC_EN adds the EXC state for signed overflow and invalid instructions.
module control_fsm
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       mem_ready,
  output logic       mux_a_sel,
  output logic [1:0] mux_b_sel,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       epc_write,
  output state_t     dbg_state
);

  state_t    state_q, state_d;
  ctrl_out_t out_q;
  alu_op_t   rop_q, rop_d;
  alu_op_t   dec_op;
  logic      dec_valid;
  state_t    bad_next;
  logic      ovf_trap;
  logic      fetch_done;

  alu_dec u_alu_dec (
    .funct_i  (funct),
    .alu_op_o (dec_op),
    .valid_o  (dec_valid)
  );

`ifdef OVERFLOW_EXC_EN
  logic unused_inputs;
  assign unused_inputs = zero;
  assign bad_next = S_EXC;
  assign ovf_trap = overflow && ((rop_q == ALU_ADD) || (rop_q == ALU_SUB));
`else
  logic unused_inputs;
  assign unused_inputs = ^{zero, overflow};
  assign bad_next = S_FETCH;
  assign ovf_trap = 1'b0;
`endif

  assign rop_d = (state_q == S_DECODE) ? dec_op : rop_q;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = dec_valid ? S_R_EXEC : bad_next;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = bad_next;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    state_d = ovf_trap ? S_EXC : S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RESET;
      out_q   <= '0;
      rop_q   <= ALU_ADD;
    end else begin
      state_q <= state_d;
      out_q   <= state_outputs(state_d, rop_d);
      rop_q   <= rop_d;
    end
  end

  // IR load and PC+4 happen in the same cycle the fetch completes, so they follow mem_ready.
  assign fetch_done = (state_q == S_FETCH) && mem_ready;

  assign mux_a_sel     = out_q.mux_a_sel;
  assign mux_b_sel     = out_q.mux_b_sel;
  assign alu_op        = out_q.alu_op;
  assign pc_src        = out_q.pc_src;
  assign pc_write      = out_q.pc_write | fetch_done;
  assign pc_write_cond = out_q.pc_write_cond;
  assign iord          = out_q.iord;
  assign mem_read      = out_q.mem_read;
  assign mem_write     = out_q.mem_write;
  assign ir_write      = out_q.ir_write | fetch_done;
  assign reg_write     = out_q.reg_write;
  assign reg_dst       = out_q.reg_dst;
  assign mem_to_reg    = out_q.mem_to_reg;
  assign epc_write     = out_q.epc_write;
  assign dbg_state     = state_q;

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: ports clk and reset_n.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 funct  input  6  instruction bits [5:0].
REQ-006 zero  input  1  ALU zero flag.
REQ-007 overflow  input  1  ALU signed-overflow flag (used only with OVERFLOW_EXC_EN).
REQ-008 mem_ready  input  1  memory access complete this cycle.
REQ-009 mux_a_sel  output  1  ALU A source: 0 PC, 1 register A.
REQ-010 mux_b_sel  output  2  ALU B source: 00 register B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm shifted left 2.
REQ-011 alu_op  output  3  000 add, 001 sub, 010 and, 011 or.
REQ-012 pc_src  output  2  00 ALU result, 01 ALUOut register, 10 jump target, 11 exception vector.
REQ-013 Single-bit outputs: pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, epc_write.

Function
REQ-014 States: RESET, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, ADDI_EXEC, ADDI_WB, BRANCH, JUMP, EXC.
REQ-015 RESET: all outputs 0; next state FETCH unconditionally.
REQ-016 FETCH: mem_read=1, iord=0, mux_a_sel=0, mux_b_sel=01, alu_op=add; hold while mem_ready=0; in the mem_ready=1 cycle ir_write=1, pc_write=1, pc_src=00, next DECODE.
REQ-017 DECODE: mux_a_sel=0, mux_b_sel=11, alu_op=add (branch target into ALUOut); dispatch on opcode: 0x00 R_EXEC, 0x08 ADDI_EXEC, 0x23/0x2B MEM_ADDR, 0x04 BRANCH, 0x02 JUMP, other -> EXC if enabled else FETCH.
REQ-018 R_EXEC: mux_a_sel=1, mux_b_sel=00, alu_op from funct (0x20 add, 0x22 sub, 0x24 and, 0x25 or); unsupported funct treated as invalid opcode; next R_WB.
REQ-019 R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, mux_a_sel/mux_b_sel/alu_op held as R_EXEC; next FETCH.
REQ-020 ADDI_EXEC: mux_a_sel=1, mux_b_sel=10, alu_op=add; next ADDI_WB (reg_write=1, reg_dst=0, mem_to_reg=0), then FETCH.
REQ-021 MEM_ADDR: mux_a_sel=1, mux_b_sel=10, alu_op=add; next MEM_READ for 0x23, MEM_WRITE for 0x2B.
REQ-022 MEM_READ/MEM_WRITE: iord=1, mem_read resp. mem_write=1; hold until mem_ready=1; MEM_READ -> MEM_WB (reg_write=1, mem_to_reg=1, reg_dst=0) -> FETCH; MEM_WRITE -> FETCH.
REQ-023 BRANCH: mux_a_sel=1, mux_b_sel=00, alu_op=sub, pc_write_cond=1, pc_src=01; PC updates only when zero=1 (external gating); next FETCH.
REQ-024 JUMP: pc_write=1, pc_src=10; next FETCH.
REQ-025 Outputs not listed for a state SHALL be 0; unreached state encodings SHALL return to FETCH next cycle.
REQ-026 mem_ready asserted outside FETCH/MEM_READ/MEM_WRITE SHALL be ignored.

Reset
REQ-027 reset_n low at any time, including mid-memory-wait, SHALL force state RESET and all outputs 0 immediately; first FETCH one cycle after release.

Configuration
REQ-028 Macro OVERFLOW_EXC_EN defined: overflow=1 in R_EXEC with add/sub, or invalid opcode/funct, goes to EXC instead of writeback/FETCH; EXC asserts epc_write=1, pc_write=1, pc_src=11, mux_a_sel=0, mux_b_sel=01, alu_op=sub (PC-4 to EPC), then FETCH.
REQ-029 Macro undefined: EXC state, epc_write and overflow logic absent; epc_write tied 0; overflow ignored; invalid opcodes return to FETCH.

Structure
REQ-030 Shared package ctrl_pkg SHALL hold state enum, opcode/funct constants, mux_b_sel, pc_src and alu_op encodings.
REQ-031 One sub-module alu_dec SHALL map funct to alu_op plus a valid flag.

Verification
REQ-032 Reset held, release -> one RESET cycle, then FETCH with mux_b_sel=01, mem_read=1.
REQ-033 FETCH with mem_ready low 3 cycles then high -> single-cycle ir_write=pc_write=1 on 4th cycle only.
REQ-034 opcode 0x23, mem_ready=1 always -> FETCH,DECODE(sel 11),MEM_ADDR(sel 10),MEM_READ,MEM_WB(mem_to_reg=1),FETCH.
REQ-035 opcode 0x00 funct 0x22 -> R_EXEC alu_op=001 mux_b_sel=00, R_WB reg_dst=1.
REQ-036 opcode 0x04 -> BRANCH pc_write_cond=1 pc_src=01 alu_op=001; opcode 0x3F -> FETCH, or EXC with epc_write=1 when OVERFLOW_EXC_EN.
REQ-037 reset_n pulsed low during MEM_WRITE wait -> mem_write drops to 0 same cycle, restart via RESET.
